c3_param_priority_heap: RTL

//  Parametrised binary-heap priority queue for the custom SIMD/accelerator path.

---
 rtl/c3_param_priority_heap.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/c3_param_priority_heap.sv
// Binary-heap priority queue: register-array heap with one compare per cycle
// for sift-up (after push) and sift-down (after pop or replace-top).
module c3_param_priority_heap #(
   parameter  int DATA_W   = 8,
   parameter  int DEPTH    = 16,
   parameter  int MAX_HEAP = 0,
   localparam int CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] in_data,
   output logic              ready,
   output logic              out_v,
   output logic [DATA_W-1:0] out_data,
   output logic [DATA_W-1:0] top,
   output logic [CNT_W-1:0]  count,
   output logic              empty,
   output logic              full,
   output logic              ovf,
   output logic              unf
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [IDX_W-1:0] ONE_I = 1;
   localparam logic [IDX_W+1:0] TWO_W = 2;

   typedef enum logic [1:0] {IDLE, SIFT_UP, SIFT_DOWN} state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] heap_q [DEPTH];
   logic [DATA_W-1:0] heap_d [DEPTH];
   logic [CNT_W-1:0]  count_q, count_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_v_q, out_v_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic              empty_q, empty_d;
   logic              full_q, full_d;

   function automatic logic better(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
      return (MAX_HEAP != 0) ? (a > b) : (a < b);
   endfunction

   // Child indices are formed two bits wider so 2*idx+2 never wraps before
   // being compared against count.
   logic [IDX_W+1:0] l_w, r_w, cnt_w;
   logic             l_ok, r_ok;
   logic [IDX_W-1:0] l_i, r_i, c_i, par_i, cnt_i, last_i;

   always_comb begin
      l_w    = {1'b0, idx_q, 1'b1};
      r_w    = {1'b0, idx_q, 1'b0} + TWO_W;
      cnt_w  = {{(IDX_W + 2 - CNT_W){1'b0}}, count_q};
      l_ok   = l_w < cnt_w;
      r_ok   = r_w < cnt_w;
      l_i    = l_w[IDX_W-1:0];
      r_i    = r_w[IDX_W-1:0];
      c_i    = l_i;
      if (r_ok && better(heap_q[r_i], heap_q[l_i])) c_i = r_i;
      par_i  = (idx_q - ONE_I) >> 1;
      cnt_i  = count_q[IDX_W-1:0];
      last_i = cnt_i - ONE_I;
   end

   always_comb begin
      state_d    = state_q;
      heap_d     = heap_q;
      count_d    = count_q;
      idx_d      = idx_q;
      out_data_d = out_data_q;
      out_v_d    = 1'b0;
      ovf_d      = 1'b0;
      unf_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (pop && empty_q) unf_d = 1'b1;
            if (pop && !empty_q && push) begin
               out_data_d = heap_q[0];
               out_v_d    = 1'b1;
               heap_d[0]  = in_data;
               idx_d      = '0;
               state_d    = SIFT_DOWN;
            end else if (pop && !empty_q) begin
               out_data_d = heap_q[0];
               out_v_d    = 1'b1;
               heap_d[0]  = heap_q[last_i];
               count_d    = count_q - 1'b1;
               idx_d      = '0;
               if (count_q > CNT_W'(2)) state_d = SIFT_DOWN;
            end else if (push) begin
               if (full_q) begin
                  ovf_d = 1'b1;
               end else begin
                  heap_d[cnt_i] = in_data;
                  idx_d         = cnt_i;
                  count_d       = count_q + 1'b1;
                  if (!empty_q) state_d = SIFT_UP;
               end
            end
         end
         SIFT_UP: begin
            if (better(heap_q[idx_q], heap_q[par_i])) begin
               heap_d[idx_q] = heap_q[par_i];
               heap_d[par_i] = heap_q[idx_q];
               idx_d         = par_i;
               if (par_i == '0) state_d = IDLE;
            end else begin
               state_d = IDLE;
            end
         end
         SIFT_DOWN: begin
            if (l_ok && better(heap_q[c_i], heap_q[idx_q])) begin
               heap_d[idx_q] = heap_q[c_i];
               heap_d[c_i]   = heap_q[idx_q];
               idx_d         = c_i;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      empty_d = count_d == '0;
      full_d  = count_d == CNT_W'(DEPTH);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         for (int i = 0; i < DEPTH; i++) heap_q[i] <= '0;
         count_q    <= '0;
         idx_q      <= '0;
         out_data_q <= '0;
         out_v_q    <= 1'b0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         heap_q     <= heap_d;
         count_q    <= count_d;
         idx_q      <= idx_d;
         out_data_q <= out_data_d;
         out_v_q    <= out_v_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
         empty_q    <= empty_d;
         full_q     <= full_d;
      end
   end

   assign ready    = state_q == IDLE;
   assign out_v    = out_v_q;
   assign out_data = out_data_q;
   assign top      = heap_q[0];
   assign count    = count_q;
   assign empty    = empty_q;
   assign full     = full_q;
   assign ovf      = ovf_q;
   assign unf      = unf_q;

endmodule
